// File: rtl/bits_rx_pwm_pkg.sv
// Shared types and constants for the N-channel serial-to-PWM receiver.
// Latency: none (declarations only).
// Backpressure: none; the serial line cannot be stalled.
package bits_rx_pwm_pkg;

  // Receiver FSM states. PARITY is only reachable when
  // BITS_RX_PWM_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Line levels of the framing bits.
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register, wrap-synchronous active register,
// registered compare. Latency: new duty seen on pwm 1 clock after the next wrap.
// Backpressure: none; a write simply overwrites the shadow.
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   cnt        shared free-running period counter
//   wrap       high on the last count of the period (cnt at all ones)
//   wr         write strobe for this channel's shadow
//   wr_duty    duty value written on wr
//   pwm        registered PWM output
module pwm_channel
  import bits_rx_pwm_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt,
  input  logic             wrap,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_duty,
  output logic             pwm
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;

  // active only changes at the period boundary so a period is never cut
  // short; a write landing on the wrap cycle is picked up one period later
  // because active samples the pre-write shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      active <= '0;
      pwm    <= 1'b0;
    end else begin
      if (wr) begin
        shadow <= wr_duty;
      end
      if (wrap) begin
        active <= shadow;
      end
      // duty 0 never satisfies the compare; all-ones misses only at the
      // final count, giving one low clock per period.
      pwm <= (cnt < active);
    end
  end

endmodule

// File: rtl/bits_rx_pwm_nch.sv
// N-channel serial-to-PWM modulator: framed {idx, duty} words on one serial
// line update per-channel duty registers. Latency: pulse 1 clock after the
// stop-bit sample; duty visible 1 clock after the following counter wrap.
// Backpressure: none; frames may arrive back-to-back.
//
// Optional feature macro: BITS_RX_PWM_PARITY_EN adds an even-parity bit over
// the index and duty fields, placed between the duty field and the stop bit.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   data        serial input, idle high, asynchronous to clk
//   pwm         N_CH PWM outputs
//   duty_valid  one-cycle pulse on frame accept
//   frame_err   one-cycle pulse on frame reject
module bits_rx_pwm_nch
  import bits_rx_pwm_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 10,
  parameter int BIT_DIV = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            data,
  output logic [N_CH-1:0] pwm,
  output logic            duty_valid,
  output logic            frame_err
);

  localparam int CH_BITS = $clog2(N_CH);
  localparam int NBITS   = CH_BITS + WIDTH;
  localparam int CW      = $clog2(BIT_DIV + 1);
  localparam int IW      = $clog2(NBITS);

  // Synchronizer plus one extra flop for falling-edge detection. All reset
  // high so reset release on an idle line never looks like a start edge.
  logic sync1;
  logic sync2;
  logic data_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      data_d <= 1'b1;
    end else begin
      sync1  <= data;
      sync2  <= sync1;
      data_d <= sync2;
    end
  end

  logic fall;
  assign fall = data_d & ~sync2;

  rx_state_t          state;
  logic [CW-1:0]      bit_cnt;
  logic [IW-1:0]      bit_idx;
  logic [NBITS-1:0]   sh;
  logic               tick;
  logic [CH_BITS-1:0] idx;
  logic [WIDTH-1:0]   duty;
  logic               idx_ok;
  logic               par_good;

  // bit_cnt counts down to 1; the cycle it reads 1 is the sample point.
  // Loading BIT_DIV/2 from the start edge centres every later sample.
  assign tick = (bit_cnt == CW'(1));

  // Fields arrive LSB first into the top of sh, so once full the first
  // received bit sits at sh[0].
  assign idx    = sh[CH_BITS-1:0];
  assign duty   = sh[NBITS-1:CH_BITS];
  assign idx_ok = (32'(idx) < 32'(N_CH));

`ifdef BITS_RX_PWM_PARITY_EN
  logic par_ok;
  assign par_good = par_ok;
`else
  assign par_good = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      sh         <= '0;
      duty_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef BITS_RX_PWM_PARITY_EN
      par_ok     <= 1'b1;
`endif
    end else begin
      duty_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state   <= START;
            bit_cnt <= CW'(BIT_DIV / 2);
          end
        end
        START: begin
          if (tick) begin
            // A line already back high at mid-bit was a glitch: drop it quietly.
            if (sync2 == START_LVL) begin
              state   <= DATA;
              bit_cnt <= CW'(BIT_DIV);
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            sh      <= {sync2, sh[NBITS-1:1]};
            bit_cnt <= CW'(BIT_DIV);
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IW'(NBITS - 1)) begin
`ifdef BITS_RX_PWM_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
`ifdef BITS_RX_PWM_PARITY_EN
        PARITY: begin
          if (tick) begin
            // Even parity: data bits plus parity bit hold an even number of ones.
            par_ok  <= ~(^sh ^ sync2);
            bit_cnt <= CW'(BIT_DIV);
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state <= IDLE;
            if ((sync2 == STOP_LVL) && idx_ok && par_good) begin
              duty_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shared period counter; wrap marks the last count before rolling to 0.
  logic [WIDTH-1:0] cnt;
  logic             wrap;

  assign wrap = &cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // sh is stable while duty_valid is high (the next frame cannot reach
  // DATA for at least half a bit), so it feeds the shadow write directly.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt),
      .wrap    (wrap),
      .wr      (duty_valid && (idx == CH_BITS'(i))),
      .wr_duty (duty),
      .pwm     (pwm[i])
    );
  end

endmodule

// File: tb/tb_bits_rx_pwm_nch.sv
// Bench for bits_rx_pwm_nch: a 4-channel and a 3-channel instance share one
// serial line; a frame-level model tracks expected pulses and duty per channel.
// PWM is checked as high-clock count over one full period in steady state.
module tb_bits_rx_pwm_nch;

  localparam int BIT_DIV = 16;
  localparam int PERIOD  = 1024;
`ifdef BITS_RX_PWM_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data = 1'b1;
  logic [3:0] pwm4;
  logic [2:0] pwm3;
  logic       dv4, fe4, dv3, fe3;

  always #5 clk = ~clk;

  bits_rx_pwm_nch #(.N_CH(4), .WIDTH(10), .BIT_DIV(BIT_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .pwm        (pwm4),
    .duty_valid (dv4),
    .frame_err  (fe4)
  );

  bits_rx_pwm_nch #(.N_CH(3), .WIDTH(10), .BIT_DIV(BIT_DIV)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .pwm        (pwm3),
    .duty_valid (dv3),
    .frame_err  (fe3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Observed pulse counts (every high cycle counts, so a stretched pulse shows).
  int dv4_n = 0, fe4_n = 0, dv3_n = 0, fe3_n = 0;
  always @(negedge clk) begin
    if (rst) begin
      if (dv4) dv4_n++;
      if (fe4) fe4_n++;
      if (dv3) dv3_n++;
      if (fe3) fe3_n++;
    end
  end

  // Reference model: duty per channel and expected pulse counts.
  int sh4[4];
  int sh3[3];
  int exp_dv4 = 0, exp_fe4 = 0, exp_dv3 = 0, exp_fe3 = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) sh4[i] = 0;
    for (int i = 0; i < 3; i++) sh3[i] = 0;
  endtask

  task automatic send_frame(input int ch, input int duty, input bit stop_b, input bit bad_par);
    bit q[$];
    bit par;
    bit ok;
    par = (^ch[1:0]) ^ (^duty[9:0]);
    q.push_back(1'b0);
    for (int i = 0; i < 2; i++) q.push_back(ch[i]);
    for (int i = 0; i < 10; i++) q.push_back(duty[i]);
    if (PAR_EN) q.push_back(par ^ bad_par);
    q.push_back(stop_b);
    foreach (q[k]) begin
      data = q[k];
      repeat (BIT_DIV) @(posedge clk);
      #1;
    end
    data = 1'b1;
    ok = stop_b && !(PAR_EN && bad_par);
    if (ok) begin
      exp_dv4++;
      sh4[ch] = duty;
      if (ch < 3) begin
        exp_dv3++;
        sh3[ch] = duty;
      end else begin
        exp_fe3++;
      end
    end else begin
      exp_fe4++;
      exp_fe3++;
    end
  endtask

  task automatic check_pulses(input string tag);
    chk({tag, "_dv4"}, dv4_n, exp_dv4);
    chk({tag, "_fe4"}, fe4_n, exp_fe4);
    chk({tag, "_dv3"}, dv3_n, exp_dv3);
    chk({tag, "_fe3"}, fe3_n, exp_fe3);
  endtask

  // Wait past the next wrap, then count high clocks over one full period.
  task automatic check_pwm(input string tag);
    int hi4[4];
    int hi3[3];
    for (int i = 0; i < 4; i++) hi4[i] = 0;
    for (int i = 0; i < 3; i++) hi3[i] = 0;
    repeat (PERIOD + 8) @(posedge clk);
    for (int c = 0; c < PERIOD; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (pwm4[i]) hi4[i]++;
      for (int i = 0; i < 3; i++) if (pwm3[i]) hi3[i]++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("%s_pwm4_%0d", tag, i), hi4[i], sh4[i]);
    for (int i = 0; i < 3; i++) chk($sformatf("%s_pwm3_%0d", tag, i), hi3[i], sh3[i]);
  endtask

  initial begin
    int ch, duty, gap;
    bit stop_b;
    model_reset();

    // Reset pulse.
    rst  = 1'b0;
    data = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm4", int'(pwm4), 0);
    chk("rst_pwm3", int'(pwm3), 0);
    chk("rst_dv", int'(dv4) + int'(dv3), 0);
    chk("rst_fe", int'(fe4) + int'(fe3), 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_pwm("idle");

    // Half duty on channel 2.
    send_frame(2, 512, 1'b1, 1'b0);
    check_pulses("ch2");
    check_pwm("ch2");

    // Boundary duties on channel 0.
    send_frame(0, 1023, 1'b1, 1'b0);
    check_pulses("max");
    check_pwm("max");
    send_frame(0, 0, 1'b1, 1'b0);
    check_pulses("zero");
    check_pwm("zero");

    // Stop bit low: rejected by both instances.
    send_frame(1, 77, 1'b0, 1'b0);
    repeat (BIT_DIV) @(posedge clk);
    #1;
    check_pulses("badstop");

    // Index 3: valid for 4 channels, out of range for 3.
    send_frame(3, 300, 1'b1, 1'b0);
    check_pulses("idx3");
    check_pwm("idx3");

    // Short glitch on idle line, then a normal frame.
    data = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    data = 1'b1;
    repeat (3 * BIT_DIV) @(posedge clk);
    #1;
    check_pulses("glitch");
    send_frame(1, 100, 1'b1, 1'b0);
    check_pulses("postglitch");

    if (PAR_EN) begin
      send_frame(1, 3, 1'b1, 1'b1);
      check_pulses("badpar");
      send_frame(1, 3, 1'b1, 1'b0);
      check_pulses("goodpar");
    end

    // Random frames, some back-to-back, some with a bad stop bit.
    for (int n = 0; n < 12; n++) begin
      ch     = int'($urandom_range(0, 3));
      duty   = int'($urandom_range(0, 1023));
      stop_b = ($urandom_range(0, 4) != 0);
      gap    = int'($urandom_range(0, 1)) * int'($urandom_range(1, 20));
      send_frame(ch, duty, stop_b, 1'b0);
      check_pulses($sformatf("rnd%0d", n));
      if (!stop_b) gap += BIT_DIV;
      repeat (gap) @(posedge clk);
      #1;
      if (n % 4 == 3) check_pwm($sformatf("rnd%0d", n));
    end

    // Reset in the middle of a frame.
    data = 1'b0;
    repeat (3 * BIT_DIV) @(posedge clk);
    #1;
    data = 1'b1;
    rst  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("midrst_pwm4", int'(pwm4), 0);
    chk("midrst_pwm3", int'(pwm3), 0);
    chk("midrst_dv", int'(dv4) + int'(dv3), 0);
    rst = 1'b1;
    repeat (20 * BIT_DIV) @(posedge clk);
    #1;
    check_pulses("midrst");
    check_pwm("midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bits_rx_pwm_nch.md
# bits_rx_pwm_nch

Parametrised N-channel serial-to-PWM modulator, the successor to the single-channel bit receiver/PWM block. It receives framed duty-cycle words on one serial line and drives `N_CH` independent PWM outputs. Everything runs in a single clock domain. An internal prescaler replaces the separate bit clock, and each PWM output updates glitch-free at the end of its period.

## Interface
- `N_CH`, 4: number of PWM channels (≥2).
- `WIDTH`, 10: duty/counter width; PWM period = 2^WIDTH clocks.
- `BIT_DIV`, 16: clocks per serial bit (≥4, even).
- `CH_BITS`: localparam = $clog2(N_CH); width of the channel-index field.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `data`  in  1  serial input, idle high, asynchronous to `clk`.
- `pwm`  out  N_CH  PWM outputs.
- `duty_valid`  out  1  one-cycle pulse when a frame is accepted.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- `data` passes through a 2-flop synchronizer; both flops reset to 1.
- Frame, all fields LSB first: start bit (0), CH_BITS channel index, WIDTH duty bits, optional parity bit, stop bit (1).
- Receiver FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a synchronized falling edge; the bit counter loads BIT_DIV/2.
  - START samples at mid-bit. If the sample is 0, go to DATA. If it is 1 (glitch), return to IDLE with no error.
  - DATA shifts in CH_BITS+WIDTH bits, one sample every BIT_DIV clocks, then goes to PARITY (macro defined) or STOP.
  - STOP checks the stop bit. If it is 1 and the index is < N_CH (and parity is OK), the frame is accepted. Otherwise the frame is rejected.
  - STOP always returns to IDLE.
- On accept: write duty into `shadow[idx]` and pulse `duty_valid`.
- On reject (stop = 0, idx ≥ N_CH, or parity failure): discard the frame, pulse `frame_err`, leave all shadows unchanged.
- PWM counter: shared, WIDTH bits, free-running, wraps from 2^WIDTH−1 to 0.
  - At wrap, every `active[i]` loads `shadow[i]`.
  - `pwm[i]` = registered (cnt < active[i]).
- Duty boundary values:
  - Duty 0: output constantly low.
  - Duty 2^WIDTH−1: output low for exactly 1 clock per period.
- An accept on the same cycle as a wrap writes the shadow; the active value picks it up at the next wrap, not the current one.
- Back-to-back frames are legal: a new start edge may be detected on the cycle after STOP completes.

## Timing
- Reset values: `pwm` = 0, `duty_valid` = 0, `frame_err` = 0, all shadow/active = 0, cnt = 0, FSM = IDLE.
- Reset asserted mid-frame aborts the frame with no pulse. Reception resumes only on a fresh falling edge after reset releases.
- Input latency: falling edge on `data` reaches the FSM after 2 clocks (synchronizer).
- `duty_valid` / `frame_err` assert 1 clock after the stop-bit sample.
- Duty change visible on `pwm[i]` 1 clock after the next counter wrap following the accept.
- Frame length: (2 + CH_BITS + WIDTH [+1]) × BIT_DIV clocks.

## Configuration
- `BITS_RX_PWM_PARITY_EN` defined:
  - An even-parity bit over the index and duty fields follows the duty field.
  - A parity mismatch rejects the frame with `frame_err`.
- Not defined: there is no PARITY state, and the stop bit directly follows the duty field.

## Structure
- Package `bits_rx_pwm_pkg` holds:
  - the receiver state enum (IDLE, START, DATA, PARITY, STOP);
  - the start- and stop-bit level constants.
- Sub-module `pwm_channel`: one instance per channel. It contains the shadow/active registers, the wrap-load logic and the compare register. The shared counter and wrap strobe are inputs.
- Top level: synchronizer, prescaler, FSM, shift register, channel decode, generate loop of `pwm_channel`.

## Test plan
All scenarios use N_CH=4, WIDTH=10, BIT_DIV=16.
- Reset pulse (`rst` low for 2 clocks) → all outputs 0, `pwm` = 4'b0000 for a full 1024-clock period.
- Frame with ch=2, duty=512 → one `duty_valid` pulse; after the next wrap, `pwm[2]` is high 512 of 1024 clocks; other channels stay low.
- Frame with ch=0, duty=1023, then ch=0, duty=0 → `pwm[0]` is low for exactly 1 clock per period, then constant low from the following wrap.
- Frame with stop bit = 0, and a separate frame with index 3 under N_CH=3 → `frame_err` pulses, no `duty_valid`, shadows unchanged.
- 4-clock low glitch on an idle line → returns to IDLE, no pulse; then a valid frame ch=1, duty=100 → accepted normally.
- With `BITS_RX_PWM_PARITY_EN`: frame ch=1, duty=3 with a wrong parity bit → `frame_err`; the same frame with correct parity → `duty_valid`. Separately, assert `rst` mid-frame → no pulse, outputs reset.
